fetch_unit: RTL and testbench

- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Holds the fetch PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers one returned instruction with its PC and PC+4, and presents them to IF/ID with a valid flag.
- Honours stall from the hazard unit and redirect (branch/jump) from EX.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, issues one outstanding request
// at a time to instruction memory, and buffers the returned instruction for IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    typedef enum logic [0:0] {StReq, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        discard_q, discard_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcplus4_q, pcplus4_d;

    logic        buffer_free;
    logic        req;
    logic        req_fire;
    logic        in_wait;
    logic        load;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Request only when the buffer is empty or draining, so a response never
    // overwrites a live entry. Gated by reset so nothing is issued during reset.
    always_comb begin
        buffer_free = !valid_q || !stall_i;
        in_wait     = (state_q == StWait);
        req         = reset && (state_q == StReq) && buffer_free;
        req_fire    = req && imem_gnt_i;
        load        = in_wait && imem_rvalid_i && !discard_q && !redirect_i;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect never changes the REQ/WAIT sequencing itself.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq:   if (req_fire) state_d = StWait;
            StWait:  if (imem_rvalid_i) state_d = StReq;
            default: state_d = StReq;
        endcase
    end

    // Datapath next-state: fetch PC, discard flag and output buffer.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pcplus4_d  = pcplus4_q;

        if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end

        if (load) begin
            instr_d    = imem_rdata_i;
            pc_d       = fetch_pc_q;
            pcplus4_d  = fetch_pc_q + 32'd4;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (in_wait && imem_rvalid_i) begin
            discard_d = 1'b0;
        end

        if (redirect_i) begin
            fetch_pc_d = redirect_target;
            valid_d    = 1'b0;
            // Only one request can be in flight, so one flag marks it stale.
            if ((in_wait && !imem_rvalid_i) || req_fire) begin
                discard_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'd0;
            pcplus4_q  <= 32'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pcplus4_q  <= pcplus4_d;
        end
    end

    // Outputs.
    always_comb begin
        imem_req_o  = req;
        imem_addr_o = fetch_pc_q;
        instr_o     = valid_q ? instr_q : NOP_INSTR;
        pc_o        = pc_q;
        pcplus4_o   = pcplus4_q;
        valid_o     = valid_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change on the falling edge, outputs
// are checked 1 time unit later.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pcplus4_o;
    logic        valid_o;

    int tests  = 0;
    int failed = 0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pcplus4_o     (pcplus4_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic g, input logic rv, input logic [31:0] rdat);
        @(negedge clk);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdat;
        #1;
    endtask

    task automatic chk_buf(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic [31:0] p4);
        chk({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
        chk({tag, "_instr"}, instr_o, i);
        chk({tag, "_pc"}, pc_o, p);
        chk({tag, "_pc4"}, pcplus4_o, p4);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, r});
        if (r) chk({tag, "_addr"}, imem_addr_o, a);
    endtask

    initial begin
        reset = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        #1;
        chk_buf("rst", 1'b0, Nop, 32'h0, 32'h0);
        chk_req("rst", 1'b0, 32'h0);

        // Zero-wait memory after reset release.
        @(negedge clk);
        reset = 1'b1; imem_gnt_i = 1'b1;
        #1;
        chk_req("z0", 1'b1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h1111_1111);
        chk_req("z0w", 1'b0, 32'h0);
        chk("z0_notyet", {31'd0, valid_o}, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        chk_buf("z0b", 1'b1, 32'h1111_1111, 32'h0, 32'h4);
        chk_req("z1", 1'b1, 32'h4);
        step(0, 0, 0, 0, 1, 32'h2222_2222);
        chk("z1_cons", {31'd0, valid_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk_buf("z1b", 1'b1, 32'h2222_2222, 32'h4, 32'h8);

        // Grant withheld three cycles: request stable.
        chk_req("g0", 1'b1, 32'h8);
        step(0, 0, 0, 0, 0, 0);
        chk_req("g1", 1'b1, 32'h8);
        chk("g1_valid", {31'd0, valid_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk_req("g2", 1'b1, 32'h8);
        step(0, 0, 0, 1, 0, 0);
        chk_req("g3", 1'b1, 32'h8);
        step(0, 0, 0, 0, 1, 32'h3333_3333);
        chk("g_wait_valid", {31'd0, valid_o}, 32'd0);

        // Stall with buffer full for 4 cycles.
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, 0, 0);
            chk_buf("st", 1'b1, 32'h3333_3333, 32'h8, 32'hC);
            chk_req("st", 1'b0, 32'h0);
        end
        step(0, 0, 0, 1, 0, 0);
        chk_req("st_rel", 1'b1, 32'hC);

        // Redirect while waiting; late data is dropped.
        step(0, 1, 32'h0000_0103, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("rw_flush", {31'd0, valid_o}, 32'd0);
        chk_req("rw_w", 1'b0, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk("rw_drop", {31'd0, valid_o}, 32'd0);
        chk_req("rw_new", 1'b1, 32'h100);
        step(0, 0, 0, 0, 1, 32'h4444_4444);
        step(0, 0, 0, 1, 0, 0);
        chk_buf("rw_b", 1'b1, 32'h4444_4444, 32'h100, 32'h104);
        chk_req("rw_nx", 1'b1, 32'h104);

        // Redirect in the same cycle as rvalid.
        step(0, 1, 32'h0000_0200, 0, 1, 32'hBAD0_BAD0);
        step(0, 0, 0, 1, 0, 0);
        chk("rv_drop", {31'd0, valid_o}, 32'd0);
        chk_req("rv_new", 1'b1, 32'h200);
        step(0, 0, 0, 0, 1, 32'h5555_5555);
        step(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
        chk_buf("rv_b", 1'b1, 32'h5555_5555, 32'h200, 32'h204);
        chk_req("rs_stall", 1'b0, 32'h0);

        // Redirect under stall with full buffer, to the top of memory.
        step(1, 0, 0, 1, 0, 0);
        chk("rs_flush", {31'd0, valid_o}, 32'd0);
        chk_req("rs_new", 1'b1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 1, 32'h6666_6666);
        step(0, 0, 0, 1, 0, 0);
        chk_buf("wrap", 1'b1, 32'h6666_6666, 32'hFFFF_FFFC, 32'h0);
        chk_req("wrap_nx", 1'b1, 32'h0);

        // Reset asserted while in WAIT.
        step(0, 0, 0, 0, 0, 0);
        chk_req("w_wait", 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk_buf("mrst", 1'b0, Nop, 32'h0, 32'h0);
        chk_req("mrst", 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_req("mrst_rel", 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
